// File: rtl/led_pkg.sv
// Shared constants and state encoding for the LED driver frame-buffer logic.
package led_pkg;

  localparam int ADDR_W = 9;
  localparam int DATA_W = 16;
  localparam int LINE_W = 5;
  localparam int COLS   = 16;
  localparam int COL_W  = $clog2(COLS);

  typedef enum logic [1:0] {
    IDLE,
    RD,
    WSLOT,
    DRAIN
  } fb_state_t;

endpackage

// File: rtl/fb_scan_arbiter_if.sv
// Request, SRAM and line-buffer signals of the frame SRAM arbiter.
// slave = arbiter side, master = scan timing / host / SRAM side.
interface fb_scan_arbiter_if #(
  parameter int ADDR_W = led_pkg::ADDR_W,
  parameter int DATA_W = led_pkg::DATA_W,
  parameter int LINE_W = led_pkg::LINE_W
);

  logic              line_start;
  logic [LINE_W-1:0] line_idx;
  logic              fetch_done;
  logic              overrun;

  logic              wr_req;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              wr_ack;

  logic              sram_cen_n;
  logic              sram_wen_n;
  logic [ADDR_W-1:0] sram_addr;
  logic [DATA_W-1:0] sram_d;
  logic [DATA_W-1:0] sram_q;

  logic              lb_we;
  logic [3:0]        lb_idx;
  logic [DATA_W-1:0] lb_data;

  modport slave (
    input  line_start, line_idx, wr_req, wr_addr, wr_data, sram_q,
    output fetch_done, overrun, wr_ack,
           sram_cen_n, sram_wen_n, sram_addr, sram_d,
           lb_we, lb_idx, lb_data
  );

  modport master (
    output line_start, line_idx, wr_req, wr_addr, wr_data, sram_q,
    input  fetch_done, overrun, wr_ack,
           sram_cen_n, sram_wen_n, sram_addr, sram_d,
           lb_we, lb_idx, lb_data
  );

endinterface

// File: rtl/lb_capture_pipe.sv
// Aligns SRAM read data with its column: one stage covers the SRAM read
// latency, the second registers the line-buffer write and fetch_done.
module lb_capture_pipe #(
  parameter int DATA_W = led_pkg::DATA_W
) (
  input  logic              GCK,
  input  logic              rst,
  input  logic              issue_valid,
  input  logic [3:0]        issue_col,
  input  logic [DATA_W-1:0] sram_q,
  output logic              lb_we,
  output logic [3:0]        lb_idx,
  output logic [DATA_W-1:0] lb_data,
  output logic              fetch_done,
  output logic              last_pending
);
  import led_pkg::*;

  localparam logic [3:0] COL_LAST = 4'(COLS - 1);

  logic       s0_valid_reg;
  logic [3:0] s0_col_reg;

  // The final column is one edge away from landing in the line buffer.
  assign last_pending = s0_valid_reg && (s0_col_reg == COL_LAST);

  always_ff @(posedge GCK or posedge rst) begin
    if (rst) begin
      s0_valid_reg <= 1'b0;
      s0_col_reg   <= '0;
      lb_we        <= 1'b0;
      lb_idx       <= '0;
      lb_data      <= '0;
      fetch_done   <= 1'b0;
    end else begin
      s0_valid_reg <= issue_valid;
      s0_col_reg   <= issue_col;
      lb_we        <= s0_valid_reg;
      fetch_done   <= last_pending;
      if (s0_valid_reg) begin
        lb_idx  <= s0_col_reg;
        lb_data <= sram_q;
      end
    end
  end

endmodule

// File: rtl/fb_scan_arbiter.sv
// Frame SRAM scheduler: 16-word scanline prefetch bursts plus host writes.
// Define FB_SCAN_WR_STARVE_EN to allow a one-cycle write slot mid-burst.
module fb_scan_arbiter #(
  parameter int ADDR_W      = led_pkg::ADDR_W,
  parameter int DATA_W      = led_pkg::DATA_W,
  parameter int LINE_W      = led_pkg::LINE_W,
  parameter int WR_WAIT_MAX = 4
) (
  input  logic               GCK,
  input  logic               rst,
  fb_scan_arbiter_if.slave   bus
);
  import led_pkg::*;

  localparam logic [COL_W-1:0] COL_LAST = COL_W'(COLS - 1);

  if (ADDR_W != LINE_W + COL_W) begin : g_bad_addr_w
    $error("fb_scan_arbiter: ADDR_W must equal LINE_W + 4");
  end
  if (WR_WAIT_MAX < 1 || WR_WAIT_MAX > 15) begin : g_bad_wait_max
    $error("fb_scan_arbiter: WR_WAIT_MAX must be in 1..15");
  end

  fb_state_t         state_reg;
  logic [LINE_W-1:0] line_reg;
  logic [COL_W-1:0]  col_reg;
  logic [3:0]        wait_reg;
  logic              issue_reg;
  logic [COL_W-1:0]  issue_col_reg;

  logic wr_ok;
  logic starve;
  logic do_read;
  logic do_write;
  logic last_pending;

  // A request still high during its ack cycle is the old one; skip it.
  assign wr_ok = bus.wr_req && !bus.wr_ack;

`ifdef FB_SCAN_WR_STARVE_EN
  assign starve = wr_ok && (wait_reg >= 4'(WR_WAIT_MAX));
`else
  assign starve = 1'b0;
`endif

  always_comb begin
    do_read  = 1'b0;
    do_write = 1'b0;
    case (state_reg)
      IDLE:  do_write = !bus.line_start && wr_ok;
      RD: begin
        do_write = starve;
        do_read  = !starve;
      end
      WSLOT: do_read = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge GCK or posedge rst) begin
    if (rst) begin
      state_reg      <= IDLE;
      line_reg       <= '0;
      col_reg        <= '0;
      wait_reg       <= '0;
      issue_reg      <= 1'b0;
      issue_col_reg  <= '0;
      bus.sram_cen_n <= 1'b1;
      bus.sram_wen_n <= 1'b1;
      bus.sram_addr  <= '0;
      bus.sram_d     <= '0;
      bus.wr_ack     <= 1'b0;
      bus.overrun    <= 1'b0;
    end else begin
      bus.sram_cen_n <= 1'b1;
      bus.sram_wen_n <= 1'b1;
      bus.wr_ack     <= 1'b0;
      issue_reg      <= 1'b0;

      if (bus.line_start && state_reg != IDLE) begin
        bus.overrun <= 1'b1;
      end

      if (do_write || bus.wr_ack) begin
        wait_reg <= '0;
      end else if (bus.wr_req && wait_reg != 4'hF) begin
        wait_reg <= wait_reg + 4'd1;
      end

      if (do_write) begin
        bus.sram_cen_n <= 1'b0;
        bus.sram_wen_n <= 1'b0;
        bus.sram_addr  <= bus.wr_addr;
        bus.sram_d     <= bus.wr_data;
        bus.wr_ack     <= 1'b1;
      end

      if (do_read) begin
        bus.sram_cen_n <= 1'b0;
        bus.sram_addr  <= {line_reg, col_reg};
        issue_reg      <= 1'b1;
        issue_col_reg  <= col_reg;
        col_reg        <= col_reg + 1'b1;
      end

      // WSLOT is the cycle the granted write occupies the SRAM port.
      case (state_reg)
        IDLE: begin
          if (bus.line_start) begin
            state_reg <= RD;
            line_reg  <= bus.line_idx;
            col_reg   <= '0;
          end
        end
        RD: begin
          if (starve) begin
            state_reg <= WSLOT;
          end else if (col_reg == COL_LAST) begin
            state_reg <= DRAIN;
          end
        end
        WSLOT:   state_reg <= (col_reg == COL_LAST) ? DRAIN : RD;
        DRAIN:   if (last_pending) state_reg <= IDLE;
        default: state_reg <= IDLE;
      endcase
    end
  end

  lb_capture_pipe #(
    .DATA_W (DATA_W)
  ) u_capture (
    .GCK          (GCK),
    .rst          (rst),
    .issue_valid  (issue_reg),
    .issue_col    (issue_col_reg),
    .sram_q       (bus.sram_q),
    .lb_we        (bus.lb_we),
    .lb_idx       (bus.lb_idx),
    .lb_data      (bus.lb_data),
    .fetch_done   (bus.fetch_done),
    .last_pending (last_pending)
  );

endmodule

// File: tb/tb_fb_scan_arbiter.sv
// Scoreboard bench for fb_scan_arbiter: stimulus pushes expected captures and
// write grants, a negedge monitor pops and compares them.
module tb_fb_scan_arbiter;
  import led_pkg::*;

  logic GCK = 1'b0;
  logic rst;
  always #5 GCK = ~GCK;

  fb_scan_arbiter_if bus ();

  fb_scan_arbiter dut (
    .GCK (GCK),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    int          cyc;
    logic [3:0]  idx;
    logic [15:0] data;
  } cap_t;

  typedef struct {
    int          cyc;
    logic [8:0]  addr;
    logic [15:0] data;
  } wr_t;

  cap_t cap_q[$];
  wr_t  wr_q[$];

  logic [15:0] sram_mem [512];
  logic [15:0] ref_mem  [512];
  logic        mem_init = 1'b0;

  int cyc    = 0;
  int errors = 0;
  int checks = 0;

  always @(posedge GCK) cyc <= cyc + 1;

  // Single-port SRAM model: read data appears the cycle after the request.
  always @(posedge GCK) begin
    if (!mem_init) begin
      for (int i = 0; i < 512; i++) sram_mem[i] <= 16'(i) ^ 16'hA5A5;
      mem_init <= 1'b1;
    end else if (!bus.sram_cen_n) begin
      if (!bus.sram_wen_n) sram_mem[bus.sram_addr] <= bus.sram_d;
      else                 bus.sram_q <= sram_mem[bus.sram_addr];
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: one line per observed transaction.
  always @(negedge GCK) begin
    cap_t e;
    wr_t  w;
    if (bus.lb_we === 1'b1) begin
      $display("cap  cyc=%0d idx=%0d data=%h done=%b", cyc, bus.lb_idx, bus.lb_data, bus.fetch_done);
      if (cap_q.size() == 0) begin
        chk("cap_unexpected", 32'(bus.lb_idx), 32'hFFFF_FFFF);
      end else begin
        e = cap_q.pop_front();
        chk("cap_cycle", cyc, e.cyc);
        chk("cap_idx", 32'(bus.lb_idx), 32'(e.idx));
        chk("cap_data", 32'(bus.lb_data), 32'(e.data));
        chk("fetch_done", 32'(bus.fetch_done), 32'(e.idx == 4'd15));
      end
    end else if (bus.fetch_done !== 1'b0) begin
      chk("done_without_we", 32'(bus.fetch_done), 32'h0);
    end
    if (bus.wr_ack === 1'b1) begin
      $display("ack  cyc=%0d addr=%h data=%h", cyc, bus.sram_addr, bus.sram_d);
      if (wr_q.size() == 0) begin
        chk("ack_unexpected", 32'(bus.sram_addr), 32'hFFFF_FFFF);
      end else begin
        w = wr_q.pop_front();
        chk("ack_cycle", cyc, w.cyc);
        chk("wr_addr", 32'(bus.sram_addr), 32'(w.addr));
        chk("wr_data", 32'(bus.sram_d), 32'(w.data));
        chk("wr_strobes", 32'({bus.sram_cen_n, bus.sram_wen_n}), 32'h0);
      end
    end
  end

  task automatic check_reset(input string tag);
    $display("reset check %s", tag);
    chk({tag, "_cen_n"},  32'(bus.sram_cen_n), 32'h1);
    chk({tag, "_wen_n"},  32'(bus.sram_wen_n), 32'h1);
    chk({tag, "_addr"},   32'(bus.sram_addr), 32'h0);
    chk({tag, "_d"},      32'(bus.sram_d), 32'h0);
    chk({tag, "_lb_we"},  32'(bus.lb_we), 32'h0);
    chk({tag, "_lb_idx"}, 32'(bus.lb_idx), 32'h0);
    chk({tag, "_lb_data"}, 32'(bus.lb_data), 32'h0);
    chk({tag, "_wr_ack"}, 32'(bus.wr_ack), 32'h0);
    chk({tag, "_done"},   32'(bus.fetch_done), 32'h0);
    chk({tag, "_overrun"}, 32'(bus.overrun), 32'h0);
  endtask

  // Called 2 time units after a rising edge; t0 is the next edge.
  task automatic start_line(input logic [4:0] idx, output int t0);
    bus.line_start = 1'b1;
    bus.line_idx   = idx;
    t0 = cyc + 1;
    @(posedge GCK); #2;
    bus.line_start = 1'b0;
  endtask

  // Columns at or after slot_col are delayed one cycle by a write slot.
  task automatic push_line(input logic [4:0] line, input int t0, input int slot_col, input int ncols);
    cap_t e;
    for (int k = 0; k < ncols; k++) begin
      e.cyc  = t0 + 3 + k + ((k >= slot_col) ? 1 : 0);
      e.idx  = 4'(k);
      e.data = ref_mem[{line, 4'(k)}];
      cap_q.push_back(e);
    end
  endtask

  task automatic set_write(input logic [8:0] addr, input logic [15:0] data, input int ack_cyc);
    wr_t w;
    bus.wr_req  = 1'b1;
    bus.wr_addr = addr;
    bus.wr_data = data;
    w.cyc = ack_cyc; w.addr = addr; w.data = data;
    wr_q.push_back(w);
    ref_mem[addr] = data;
  endtask

  task automatic wait_ack();
    int n = 0;
    while (bus.wr_ack !== 1'b1 && n < 40) begin
      @(posedge GCK); #2;
      n++;
    end
    if (bus.wr_ack !== 1'b1) chk("ack_timeout", 32'(bus.wr_ack), 32'h1);
    bus.wr_req = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) begin @(posedge GCK); #2; end
  endtask

  initial begin
    int t0;
    for (int i = 0; i < 512; i++) ref_mem[i] = 16'(i) ^ 16'hA5A5;
    rst            = 1'b1;
    bus.line_start = 1'b0;
    bus.line_idx   = '0;
    bus.wr_req     = 1'b0;
    bus.wr_addr    = '0;
    bus.wr_data    = '0;
    idle_cycles(3);
    check_reset("rst0");
    rst = 1'b0;
    idle_cycles(2);

    // Plain fetch of line 3.
    start_line(5'd3, t0);
    push_line(5'd3, t0, 16, 16);
    idle_cycles(22);
    chk("overrun_clean", 32'(bus.overrun), 32'h0);

    // Idle write, then fetch the line it landed in.
    set_write(9'h1FF, 16'hBEEF, cyc + 1);
    wait_ack();
    idle_cycles(2);
    start_line(5'd31, t0);
    push_line(5'd31, t0, 16, 16);
    idle_cycles(22);

    // Fetch and write requested on the same edge.
    bus.wr_req  = 1'b1;
    bus.wr_addr = 9'h010;
    bus.wr_data = 16'h1234;
    start_line(5'd7, t0);
`ifdef FB_SCAN_WR_STARVE_EN
    set_write(9'h010, 16'h1234, t0 + 4);
    push_line(5'd7, t0, 3, 16);
`else
    set_write(9'h010, 16'h1234, t0 + 19);
    push_line(5'd7, t0, 16, 16);
`endif
    wait_ack();
    idle_cycles(6);

    // Write raised one cycle into a burst.
    start_line(5'd9, t0);
    idle_cycles(1);
`ifdef FB_SCAN_WR_STARVE_EN
    set_write(9'h0A0, 16'h5A5A, t0 + 6);
    push_line(5'd9, t0, 5, 16);
`else
    set_write(9'h0A0, 16'h5A5A, t0 + 19);
    push_line(5'd9, t0, 16, 16);
`endif
    wait_ack();
    idle_cycles(6);

    // Second line_start mid-burst is ignored and flags overrun.
    start_line(5'd12, t0);
    push_line(5'd12, t0, 16, 16);
    idle_cycles(3);
    bus.line_start = 1'b1;
    bus.line_idx   = 5'd0;
    idle_cycles(1);
    bus.line_start = 1'b0;
    idle_cycles(20);
    chk("overrun_set", 32'(bus.overrun), 32'h1);
    idle_cycles(10);
    chk("overrun_sticky", 32'(bus.overrun), 32'h1);

    // Reset in the middle of a burst.
    start_line(5'd20, t0);
    push_line(5'd20, t0, 16, 5);
    idle_cycles(8);
    rst = 1'b1;
    #1;
    check_reset("rst_mid");
    idle_cycles(2);
    rst = 1'b0;
    idle_cycles(20);
    chk("cap_after_rst", 32'(cap_q.size()), 32'h0);

    start_line(5'd2, t0);
    push_line(5'd2, t0, 16, 16);
    idle_cycles(24);
    chk("overrun_after_rst", 32'(bus.overrun), 32'h0);

    chk("cap_left", 32'(cap_q.size()), 32'h0);
    chk("wr_left", 32'(wr_q.size()), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fb_scan_arbiter.md
# fb_scan_arbiter

Single-clock scheduler and arbiter for the single-port 512x16 frame SRAM in the LED driver. It runs one 16-word scanline prefetch burst per `line_start` request from the scan/PWM timing logic and writes each fetched word into the line buffer that feeds the PWM comparators. It also serializes host pixel writes into the same SRAM port. Fetch traffic has priority; an optional starvation slot bounds write latency.

## Interface
- `ADDR_W`, 9: SRAM address width; must equal `LINE_W + 4`.
- `DATA_W`, 16: pixel word width.
- `LINE_W`, 5: scanline index width (32 lines).
- `WR_WAIT_MAX`, 4: starvation threshold in cycles; range 1..15.

- `GCK` in 1: the only clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `line_start` in 1: single-cycle request to fetch line `line_idx`.
- `line_idx` in `LINE_W`: captured on the edge where `line_start` is accepted.
- `fetch_done` out 1: single-cycle pulse.
- `overrun` out 1: sticky error flag.
- `wr_req` in 1: write request, level.
- `wr_addr` in `ADDR_W`: held stable while `wr_req` is high.
- `wr_data` in `DATA_W`: held stable while `wr_req` is high.
- `wr_ack` out 1: single-cycle grant.
- `sram_cen_n` out 1: SRAM chip enable, active-low.
- `sram_wen_n` out 1: SRAM write enable, active-low.
- `sram_addr` out `ADDR_W`: SRAM address.
- `sram_d` out `DATA_W`: SRAM write data.
- `sram_q` in `DATA_W`: SRAM read data.
- `lb_we` out 1: line buffer write strobe.
- `lb_idx` out 4: line buffer column.
- `lb_data` out `DATA_W`: line buffer write data.

## Operation
- All outputs are registered.
- Reset values:
  - `sram_cen_n` = 1, `sram_wen_n` = 1.
  - `sram_addr`, `sram_d`, `lb_idx`, `lb_data` = 0.
  - `lb_we`, `wr_ack`, `fetch_done`, `overrun` = 0.
  - FSM in IDLE; wait counter = 0.
- FSM states: IDLE, RD, WSLOT, DRAIN.
- IDLE:
  - `line_start` high → RD. Capture `line_idx`; column counter `col` = 0.
  - Else, if `wr_req` is high and no write was acked in the previous cycle → present a write for one cycle: `sram_cen_n`=0, `sram_wen_n`=0, `sram_addr`=`wr_addr`, `sram_d`=`wr_data`, `wr_ack`=1 in that same cycle.
  - Simultaneous `line_start` and `wr_req`: the fetch wins and the write waits.
- RD, one read per cycle:
  - `sram_cen_n`=0, `sram_wen_n`=1, `sram_addr`={line, col}.
  - `col` increments; after col 15 → DRAIN.
- WSLOT: a one-cycle write slot inserted mid-burst. The read for the current `col` is deferred, `col` does not advance, then → RD.
- DRAIN: wait until the last capture completes, then → IDLE.
- Read capture: a read presented in cycle c produces `sram_q` valid in c+1. That data is registered to `lb_data` with `lb_we`=1 and `lb_idx`=col in c+2.
- `fetch_done` is high in the same cycle as the `lb_we` with `lb_idx`=15.
- Wait counter: increments each cycle `wr_req` is high and `wr_ack` is low. It saturates at 15 and clears on `wr_ack`.
- Write handshake: if `wr_req` is still high in the cycle after `wr_ack`, it is a new request. It becomes eligible only from the following cycle.
- Overrun: `line_start` in any state other than IDLE is ignored, and `overrun` is set. `overrun` clears only on `rst`.
- `rst` mid-burst: the burst is abandoned, no further `lb_we`, no `fetch_done`, and all outputs take their reset values immediately.

## Timing
- Define t0 as the edge where `line_start` is sampled in IDLE.
- Reads are presented in cycles t0+1 .. t0+16.
- `lb_we` is high in cycles t0+3 .. t0+18; `fetch_done` is high in t0+18.
- The FSM returns to IDLE at t0+19.
- Each inserted WSLOT shifts all later reads and captures by +1 cycle.
- Worst-case write latency (with the starvation slot compiled in): `WR_WAIT_MAX` + 1 cycles from `wr_req` to `wr_ack`.
- Reads, writes and captures never share an SRAM cycle. `lb_we` may coincide with a write cycle.

## Configuration
- Macro: `FB_SCAN_WR_STARVE_EN`.
- Defined: in RD, when the wait counter has reached `WR_WAIT_MAX` and `wr_req` is high, the next cycle is WSLOT and grants the write (`wr_ack`=1). At most one WSLOT is inserted per `WR_WAIT_MAX` read cycles.
- Undefined: WSLOT does not exist. Writes are granted only in IDLE, so worst-case write latency is 19 cycles plus IDLE contention.

## Structure
- Shared package `led_pkg` holds:
  - `ADDR_W`, `DATA_W`, `LINE_W`.
  - `COLS` = 16.
  - The state enum `fb_state_t` {IDLE, RD, WSLOT, DRAIN}.
- One sub-module, `lb_capture_pipe`: a 2-stage valid/column shift that aligns `sram_q` with `lb_idx` and generates `lb_we` and `fetch_done`.

## Test plan
- `line_start` with `line_idx`=3, SRAM preloaded with addr → addr^0xA5A5 → `lb_we` at t0+3..t0+18, `lb_idx` 0..15, `lb_data` = (0x30+k)^0xA5A5 for column k, `fetch_done` at t0+18.
- Idle write: `wr_req` with addr 0x1FF, data 0xBEEF → `wr_ack` and an SRAM write the next cycle; a later fetch of line 31 returns 0xBEEF at col 15.
- `line_start` and `wr_req` high on the same edge → the burst starts first; without the macro, `wr_ack` arrives at t0+19.
- With the macro and `WR_WAIT_MAX`=4: `wr_req` raised at t0+1 → one WSLOT, `wr_ack` by t0+6, `fetch_done` at t0+19.
- `line_start` at t0+5 → ignored, `overrun`=1 and stays 1 until `rst`.
- `rst` asserted at t0+8 → all outputs at reset values, no `fetch_done`; a new `line_start` after reset fetches normally.
